// File: rtl/pipe_referee.sv
// pipe_referee: scoring and collision referee for a side-scrolling bird game.
// Tracks game state (IDLE/RUN/OVER), picks a pseudo-random gap row for each
// pipe, counts pipes passed and flags a collision against pipe or floor.
module pipe_referee #(
    parameter int unsigned BIRD_X    = 200,
    parameter int unsigned PIPE_W    = 60,
    parameter int unsigned GAP_H     = 150,
    parameter int unsigned GAP_MIN   = 80,
    parameter int unsigned SCREEN_H  = 600,
    parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] pipe_x,
    input  logic        pipe_wrap,
    input  logic [11:0] bird_y,
    output logic [11:0] gap_y,
    output logic [7:0]  score,
    output logic        score_pulse,
    output logic        hit,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // Geometry constants widened to 13 bits so sums never wrap.
    localparam logic [12:0] BIRD_X13   = 13'(BIRD_X);
    localparam logic [12:0] PIPE_W13   = 13'(PIPE_W);
    localparam logic [12:0] GAP_H13    = 13'(GAP_H);
    localparam logic [12:0] SCREEN_H13 = 13'(SCREEN_H);
    localparam logic [11:0] GAP_MIN12  = 12'(GAP_MIN);
    localparam logic [11:0] RESET_GAP  = GAP_MIN12 + {4'd0, LFSR_SEED[7:0]};

    state_t      state_q, state_d;
    logic [9:0]  lfsr;
    logic        wrap_q;
    logic        scored;
    logic [11:0] gap_q;
    logic [7:0]  score_q;
    logic        pulse_q;

    logic [12:0] pipe_right;
    logic [12:0] gap_bottom;
    logic        overlap;
    logic        out_of_bounds;
    logic        outside_gap;
    logic        collide;
    logic        passed;
    logic        wrap_evt;
    logic [11:0] new_gap;
    logic        lfsr_fb;

    logic        start_game;
    logic        run_collide;
    logic        run_live;

    // Combinational game geometry and event decode.
    assign pipe_right    = {1'b0, pipe_x} + PIPE_W13;
    assign gap_bottom    = {1'b0, gap_q} + GAP_H13;
    assign overlap       = ({1'b0, pipe_x} <= BIRD_X13) && (pipe_right > BIRD_X13);
    assign out_of_bounds = {1'b0, bird_y} >= SCREEN_H13;
    assign outside_gap   = (bird_y < gap_q) || ({1'b0, bird_y} >= gap_bottom);
    assign collide       = out_of_bounds || (overlap && outside_gap);
    assign passed        = pipe_right <= BIRD_X13;
    assign wrap_evt      = pipe_wrap && !wrap_q;
    assign new_gap       = GAP_MIN12 + {4'd0, lfsr[7:0]};
    assign lfsr_fb       = lfsr[9] ^ lfsr[6];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: start launches a game, a collision ends it.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (collide) state_d = OVER;
            OVER:    if (start)   state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode from the current state.
    always_comb begin
        start_game  = 1'b0;
        run_collide = 1'b0;
        run_live    = 1'b0;
        hit         = 1'b0;
        case (state_q)
            IDLE: start_game = start;
            RUN: begin
                run_collide = collide;
                run_live    = !collide;
            end
            OVER: begin
                hit        = 1'b1;
                start_game = start;
            end
            default: ;
        endcase
    end

    // Datapath: LFSR, wrap edge detector, gap selection and scoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= LFSR_SEED;
            wrap_q  <= 1'b0;
            gap_q   <= RESET_GAP;
            score_q <= 8'd0;
            pulse_q <= 1'b0;
            scored  <= 1'b0;
        end else begin
            lfsr    <= {lfsr[8:0], lfsr_fb};
            wrap_q  <= pipe_wrap;
            pulse_q <= 1'b0;
            if (start_game) begin
                score_q <= 8'd0;
                scored  <= 1'b0;
                gap_q   <= new_gap;
            end else if (run_live) begin
                if (passed && !scored) begin
                    scored <= 1'b1;
                    if (score_q != 8'hFF) begin
                        score_q <= score_q + 8'd1;
                        pulse_q <= 1'b1;
                    end
                end
                // A fresh pipe re-arms scoring; it overrides a same-cycle set.
                if (wrap_evt) begin
                    gap_q  <= new_gap;
                    scored <= 1'b0;
                end
            end
            // A collision (run_collide) or OVER/IDLE without start holds gap and score.
        end
    end

    assign gap_y       = gap_q;
    assign score       = score_q;
    assign score_pulse = pulse_q;
    assign state       = state_q;

endmodule
